// File: rtl/spi_frame_loader.sv
// Receives length-prefixed frames from an SPI slave and writes the payload words into a quadram.
// A frame stays resident until the downstream stage pulses consume.
module spi_frame_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_WORDS  = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_done,
    input  logic [31:0]           spi_rdata,
    input  logic                  consume,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_di,
    output logic [31:0]           word_count,
    output logic                  frame_ready,
    output logic                  frame_err
);

    typedef enum logic [1:0] {
        HEADER,
        LOAD,
        READY,
        ERROR
    } state_t;

    state_t state;
    state_t state_next;

    logic sync1;
    logic sync2;
    logic sync3;
    logic word_evt;

    // One bit wider than the address so a full MAX_WORDS frame ends at 2048, not 0.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [31:0]         wr_ptr_inc;

    logic issue_write;
    logic load_header;
    logic en_q;
    logic [3:0] we_q;

    assign word_evt   = sync2 & ~sync3;
    assign wr_ptr_inc = 32'(wr_ptr) + 32'd1;

    // A write registered just before reset rises must not reach the RAM during the reset cycle.
    assign ram_en = en_q & ~reset;
    assign ram_we = we_q & {4{~reset}};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= spi_done;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HEADER;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        issue_write = 1'b0;
        load_header = 1'b0;
        case (state)
            HEADER: begin
                if (word_evt) begin
                    load_header = 1'b1;
                    if (spi_rdata == 32'd0) begin
                        state_next = READY;
                    end else if (spi_rdata > 32'(MAX_WORDS)) begin
                        state_next = ERROR;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_evt) begin
                    issue_write = 1'b1;
                    if (wr_ptr_inc == word_count) begin
                        state_next = READY;
                    end
                end
            end
            READY, ERROR: begin
                // Word events here are dropped, including one coinciding with consume.
                if (consume) begin
                    state_next = HEADER;
                end
            end
            default: state_next = HEADER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            word_count  <= 32'd0;
            en_q        <= 1'b0;
            we_q        <= 4'h0;
            ram_addr    <= '0;
            ram_di      <= 32'd0;
            frame_ready <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            en_q <= issue_write;
            we_q <= issue_write ? 4'hF : 4'h0;
            if (load_header) begin
                word_count <= spi_rdata;
                wr_ptr     <= '0;
            end
            if (issue_write) begin
                ram_addr <= wr_ptr[ADDR_WIDTH-1:0];
                ram_di   <= spi_rdata;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            frame_ready <= (state == READY) && !consume;
            frame_err   <= (state == ERROR) && !consume;
        end
    end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Randomized self-checking bench for spi_frame_loader against a frame-level reference model.
module tb_spi_frame_loader;

    localparam int AW  = 11;
    localparam int MAXW = 2048;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_done;
    logic [31:0]   spi_rdata;
    logic          consume;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_di;
    logic [31:0]   word_count;
    logic          frame_ready;
    logic          frame_err;

    spi_frame_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_done   (spi_done),
        .spi_rdata  (spi_rdata),
        .consume    (consume),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .word_count (word_count),
        .frame_ready(frame_ready),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference: what the loader should have accepted and written so far.
    typedef enum {M_HDR, M_LOAD, M_RDY, M_ERR} mode_t;
    mode_t       mode = M_HDR;
    logic [31:0] m_count = 32'd0;
    int          m_written = 0;
    int          exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic model_word(input logic [31:0] data, input bit cons, output bit wr);
        wr = 1'b0;
        case (mode)
            M_HDR: begin
                m_count   = data;
                m_written = 0;
                if (data == 0)          mode = M_RDY;
                else if (data > MAXW)   mode = M_ERR;
                else                    mode = M_LOAD;
            end
            M_LOAD: begin
                exp_addr.push_back(m_written);
                exp_data.push_back(data);
                m_written++;
                wr = 1'b1;
                if (m_written == int'(m_count)) mode = M_RDY;
            end
            default: if (cons) mode = M_HDR;
        endcase
    endtask

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (ram_en !== 1'b0) check("write_in_reset", 32'(ram_en), 32'd0);
        end else if (ram_en === 1'b1) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_write", 32'(ram_addr), 32'hFFFF_FFFF);
            end else begin
                check("wr_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
                check("wr_data", ram_di, exp_data.pop_front());
                check("wr_we", 32'(ram_we), 32'hF);
            end
        end else if (ram_we !== 4'h0) begin
            check("we_idle", 32'(ram_we), 32'd0);
        end
    end

    task automatic send_word(input logic [31:0] data, input bit cons);
        bit wr;
        bit seen;
        model_word(data, cons, wr);
        seen = 1'b0;
        spi_rdata = data;
        spi_done  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 1 && cons) consume = 1'b1;
            if (i == 2) consume = 1'b0;
            if (ram_en === 1'b1) seen = 1'b1;
        end
        spi_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (wr) check("write_latency", 32'(seen), 32'd1);
    endtask

    task automatic do_consume();
        @(posedge clk);
        #1;
        consume = 1'b1;
        if (mode == M_RDY || mode == M_ERR) mode = M_HDR;
        @(posedge clk);
        #1;
        consume = 1'b0;
        check("ready_after_consume", 32'(frame_ready), 32'd0);
        check("err_after_consume", 32'(frame_err), 32'd0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_ready"}, 32'(frame_ready), 32'(mode == M_RDY));
        check({tag, "_err"}, 32'(frame_err), 32'(mode == M_ERR));
        check({tag, "_count"}, word_count, m_count);
        check({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mode = M_HDR;
        m_count = 32'd0;
        exp_addr.delete();
        exp_data.delete();
        check("rst_ready", 32'(frame_ready), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_count", word_count, 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_di", ram_di, 32'd0);
        check("rst_en", 32'(ram_en), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len);
        send_word(32'(len), 1'b0);
        for (int i = 0; i < len; i++) send_word($urandom, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        spi_done  = 1'b0;
        spi_rdata = 32'd0;
        consume   = 1'b0;
        do_reset();

        // Basic three-word frame.
        send_word(32'd3, 1'b0);
        send_word(32'hAAAA_0001, 1'b0);
        send_word(32'hBBBB_0002, 1'b0);
        send_word(32'hCCCC_0003, 1'b0);
        check_status("frame3");
        do_consume();

        // Empty frame goes straight to ready.
        send_word(32'd0, 1'b0);
        check_status("frame0");
        do_consume();

        // Oversized header is rejected and following words are dropped.
        send_word(32'd2049, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'h9ABC_DEF0, 1'b0);
        check_status("oversize");
        do_consume();
        send_word(32'd1, 1'b0);
        send_word(32'hDDDD_DDDD, 1'b0);
        check_status("after_err");
        do_consume();

        // Random frames, with stray words in READY and some coinciding with consume.
        for (int f = 0; f < 8; f++) begin
            send_frame(int'($urandom_range(1, 8)));
            check_status("rand");
            if ($urandom_range(0, 1) == 1) begin
                send_word($urandom, 1'b0);
                check_status("rand_extra");
            end
            if ($urandom_range(0, 1) == 1) begin
                send_word($urandom, 1'b1);
                check_status("consume_collide");
            end else begin
                do_consume();
            end
        end

        // Maximum-size frame fills 0..2047 without wrapping.
        send_frame(MAXW);
        check_status("max_frame");
        check("max_last_addr", 32'(ram_addr), 32'd2047);
        do_consume();

        // Reset in the middle of a payload aborts the frame.
        send_word(32'd5, 1'b0);
        send_word(32'h0101_0101, 1'b0);
        send_word(32'h0202_0202, 1'b0);
        do_reset();
        send_word(32'd1, 1'b0);
        send_word(32'hEEEE_EEEE, 1'b0);
        check_status("after_reset");
        check("after_reset_di", ram_di, 32'hEEEE_EEEE);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
